sc_ienc: RTL and testbench
==========================

# sc_ienc

Instruction encoder and program loader for the single-cycle computer. It accepts symbolic instructions over a valid/ready handshake and packs each one into a 32-bit MIPS word, covering the same 20-instruction subset the control unit decodes. Each word is written sequentially into the instruction memory write port, so the core can be loaded with a program before `reset` is released on the datapath.

## Interface
- `ADDR_W`, default 6: instruction-memory word-address width. Capacity is 2^ADDR_W words.
- `clock`  in  1: rising-edge clock.
- `reset`  in  1: asynchronous, active-high.
- `in_valid`  in  1: the fields below hold an instruction to encode.
- `in_ready`  out  1: the encoder can accept an instruction this cycle.
- `mnem`  in  5: instruction select, 0..19 = add, sub, and, or, xor, sll, srl, sra, jr, addi, andi, ori, xori, lw, sw, beq, bne, lui, j, jal. Codes 20..31 are illegal.
- `rs`, `rt`, `rd`, `shamt`  in  5 each: register and shift-amount fields.
- `imm`  in  16: immediate field for I-type instructions.
- `target`  in  26: jump target for j/jal.
- `last`  in  1: the accepted instruction is the final one of the program.
- `im_we`  out  1: instruction-memory write strobe.
- `im_addr`  out  ADDR_W: word address of the write.
- `im_data`  out  32: encoded instruction word.
- `count`  out  ADDR_W+1: number of words written so far.
- `done`  out  1: program loaded, either because `last` was seen or because memory is full.
- `err`  out  1: sticky illegal-mnemonic flag (only when `IENC_CHECK_EN` is defined).

## Operation
- FSM states are IDLE, WRITE and DONE. Reset state is IDLE.
- IDLE
  - `in_ready` = 1.
  - An accept occurs on a rising edge with `in_valid & in_ready`.
  - On accept, register the encoded word and the current address, then go to WRITE.
- WRITE
  - `in_ready` = 0, `im_we` = 1 for exactly one cycle.
  - On exit, the address pointer and `count` increment.
  - Go to DONE if the registered `last` was set or `count` reaches 2^ADDR_W. Otherwise return to IDLE.
- DONE
  - `done` = 1, `in_ready` = 0, `im_we` = 0.
  - Holds until `reset`.
- Encoding rules:
  - R-type: {6'b000000, rs, rt, rd, shamt, func}.
  - func codes: add 100000, sub 100010, and 100100, or 100101, xor 100110, sll 000000, srl 000010, sra 000011, jr 001000.
  - sll/srl/sra force the rs field to 0.
  - jr encodes {6'b0, rs, 15'b0, 6'b001000}.
  - Non-shift R-type instructions force the shamt field to 0.
  - I-type: {op, rs, rt, imm}.
  - op codes: addi 001000, andi 001100, ori 001101, xori 001110, lw 100011, sw 101011, beq 000100, bne 000101, lui 001111.
  - lui forces the rs field to 0.
  - J-type: {op, target}, with j = 000010 and jal = 000011.
- The address pointer starts at 0 and is `ADDR_W` bits wide; it never wraps because DONE is entered when memory is full.
- `count` saturates at 2^ADDR_W.
- `imm` is passed through unmodified. Sign or zero extension is the datapath's concern.

## Timing
- Reset values:
  - `in_ready` = 1, `im_we` = 0, `im_addr` = 0, `im_data` = 0, `count` = 0, `done` = 0, `err` = 0.
- Latency: for an accept at edge N, `im_we`/`im_addr`/`im_data` are valid from edge N to edge N+1. The write commits at edge N+1.
- Throughput is one instruction per 2 cycles.
- `in_ready` drops in the cycle after an accept and returns in the cycle after the write.
- `im_addr` and `im_data` hold their last values outside WRITE.
- `done` rises at the edge ending the final WRITE.
- `reset` asserted mid-WRITE: `im_we` falls immediately (asynchronously); pointer, `count`, `done` and `err` clear.
- `in_valid` while `in_ready` = 0 is ignored. The source must hold its fields until it sees an accept.
- `last` on the word that also fills memory: go to DONE once (no double count).

## Configuration
- `IENC_CHECK_EN` defined:
  - An illegal `mnem` is still accepted (one handshake) but produces no WRITE; the FSM stays in IDLE.
  - `err` is set sticky and `count` is unchanged.
  - If `last` accompanies an illegal mnemonic, go directly to DONE.
- `IENC_CHECK_EN` undefined:
  - `err` is tied 0.
  - An illegal `mnem` encodes as 32'h00000000 (nop, the sll $0,$0,0 encoding) and is written normally.

## Test plan
- add: `mnem`=0, `rs`=1, `rt`=2, `rd`=3, `shamt`=0 -> `im_we` pulse, `im_addr`=0, `im_data`=32'h00221820, `count`=1.
- Shift and load:
  - sll with `rs`=7, `rt`=1, `rd`=2, `shamt`=4 -> 32'h00011100 (rs ignored).
  - Then lw with `rs`=5, `rt`=4, `imm`=8 -> 32'h8CA40008 at `im_addr`=1.
- jal: `target`=26'h10 with `last`=1 -> 32'h0C000010 written; `done`=1 and `in_ready`=0 on the next cycle. Further `in_valid` is ignored.
- Full: `ADDR_W`=2, four legal pushes with `last`=0 -> addresses 0..3 written, `count`=4, `done`=1, no fifth write.
- Illegal: `mnem`=25 with `IENC_CHECK_EN` -> `err`=1, no `im_we`, `count` unchanged. Without the macro -> 32'h0 written.
- Reset asserted in the `im_we` cycle -> `im_we` drops at once. After release: `im_addr`=0, `count`=0, `in_ready`=1.

Source files
------------

// File: rtl/sc_ienc_if.sv
// sc_ienc_if: bus bundle for the instruction encoder / program loader.
//
// Groups the symbolic-instruction handshake and the instruction-memory
// write port so that the encoder and its source share one connection.
//
// Handshake: an instruction transfers on a rising clock edge where both
// in_valid and in_ready are high. The source keeps mnem/rs/rt/rd/shamt/
// imm/target/last stable from the cycle it raises in_valid until that
// transfer edge. in_valid while in_ready is low has no effect.
//
// Parameter:
//   ADDR_W  instruction-memory word-address width (capacity 2^ADDR_W)
// Signals (source -> encoder):
//   in_valid, mnem[4:0], rs/rt/rd/shamt[4:0], imm[15:0], target[25:0], last
// Signals (encoder -> source / memory):
//   in_ready, im_we, im_addr[ADDR_W-1:0], im_data[31:0],
//   count[ADDR_W:0], done, err
// Modports: master = instruction source / observer, slave = encoder.
interface sc_ienc_if #(
  parameter int ADDR_W = 6
);
  logic              in_valid;
  logic              in_ready;
  logic [4:0]        mnem;
  logic [4:0]        rs;
  logic [4:0]        rt;
  logic [4:0]        rd;
  logic [4:0]        shamt;
  logic [15:0]       imm;
  logic [25:0]       target;
  logic              last;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_data;
  logic [ADDR_W:0]   count;
  logic              done;
  logic              err;

  modport master (
    output in_valid, mnem, rs, rt, rd, shamt, imm, target, last,
    input  in_ready, im_we, im_addr, im_data, count, done, err
  );

  modport slave (
    input  in_valid, mnem, rs, rt, rd, shamt, imm, target, last,
    output in_ready, im_we, im_addr, im_data, count, done, err
  );
endinterface

// File: rtl/sc_ienc.sv
// sc_ienc: instruction encoder and program loader for the single-cycle core.
//
// Accepts symbolic instructions (20-mnemonic MIPS subset), packs each into
// a 32-bit word and writes it to consecutive instruction-memory addresses,
// one write per accepted instruction, two cycles per instruction.
// Loading finishes (done) when an instruction flagged last has been handled
// or when memory is full; the block then holds until reset.
//
// Optional feature macro: IENC_CHECK_EN
//   defined   - illegal mnemonics (20..31) are accepted but not written,
//               and raise the sticky err flag.
//   undefined - illegal mnemonics encode as 32'h0 (nop) and are written;
//               err is tied low.
//
// Ports:
//   clock      rising-edge clock
//   reset      asynchronous, active-high reset
//   bus        sc_ienc_if.slave (instruction handshake + memory write port)
//   dbg_state  current FSM state (0 IDLE, 1 WRITE, 2 DONE)
module sc_ienc #(
  parameter int ADDR_W = 6
) (
  input  logic       clock,
  input  logic       reset,
  sc_ienc_if.slave   bus,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [ADDR_W:0] FULL = {1'b1, {ADDR_W{1'b0}}};

  state_t            state;
  state_t            state_nx;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W:0]   cnt;
  logic [ADDR_W:0]   cnt_inc;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       data_q;
  logic              last_q;
  logic              accept;
  logic              drop;
  logic [31:0]       enc;

  assign accept  = bus.in_valid && (state == IDLE);
  assign cnt_inc = cnt + (ADDR_W + 1)'(1);

`ifdef IENC_CHECK_EN
  logic err_q;
  // Illegal mnemonic: consumed by the handshake, never written.
  assign drop = accept && (bus.mnem > 5'd19);
`else
  assign drop = 1'b0;
`endif

  // Field packing. Codes 20..31 fall to the default nop encoding.
  always_comb begin
    enc = 32'h0000_0000;
    case (bus.mnem)
      5'd0:  enc = {6'b000000, bus.rs, bus.rt, bus.rd, 5'd0, 6'b100000};
      5'd1:  enc = {6'b000000, bus.rs, bus.rt, bus.rd, 5'd0, 6'b100010};
      5'd2:  enc = {6'b000000, bus.rs, bus.rt, bus.rd, 5'd0, 6'b100100};
      5'd3:  enc = {6'b000000, bus.rs, bus.rt, bus.rd, 5'd0, 6'b100101};
      5'd4:  enc = {6'b000000, bus.rs, bus.rt, bus.rd, 5'd0, 6'b100110};
      5'd5:  enc = {6'b000000, 5'd0, bus.rt, bus.rd, bus.shamt, 6'b000000};
      5'd6:  enc = {6'b000000, 5'd0, bus.rt, bus.rd, bus.shamt, 6'b000010};
      5'd7:  enc = {6'b000000, 5'd0, bus.rt, bus.rd, bus.shamt, 6'b000011};
      5'd8:  enc = {6'b000000, bus.rs, 15'd0, 6'b001000};
      5'd9:  enc = {6'b001000, bus.rs, bus.rt, bus.imm};
      5'd10: enc = {6'b001100, bus.rs, bus.rt, bus.imm};
      5'd11: enc = {6'b001101, bus.rs, bus.rt, bus.imm};
      5'd12: enc = {6'b001110, bus.rs, bus.rt, bus.imm};
      5'd13: enc = {6'b100011, bus.rs, bus.rt, bus.imm};
      5'd14: enc = {6'b101011, bus.rs, bus.rt, bus.imm};
      5'd15: enc = {6'b000100, bus.rs, bus.rt, bus.imm};
      5'd16: enc = {6'b000101, bus.rs, bus.rt, bus.imm};
      5'd17: enc = {6'b001111, 5'd0, bus.rt, bus.imm};
      5'd18: enc = {6'b000010, bus.target};
      5'd19: enc = {6'b000011, bus.target};
      default: enc = 32'h0000_0000;
    endcase
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (drop) state_nx = bus.last ? DONE : IDLE;
          else      state_nx = WRITE;
        end
      end
      // A last word that also fills memory takes this single exit.
      WRITE:   state_nx = (last_q || (cnt_inc == FULL)) ? DONE : IDLE;
      DONE:    state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end

  // Output logic. im_we is decoded from state so reset drops it at once.
  always_comb begin
    bus.in_ready = (state == IDLE);
    bus.im_we    = (state == WRITE);
    bus.done     = (state == DONE);
    bus.im_addr  = addr_q;
    bus.im_data  = data_q;
    bus.count    = cnt;
    dbg_state    = state;
  end

  // Write-port registers, pointer and word count.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr    <= '0;
      cnt    <= '0;
      addr_q <= '0;
      data_q <= '0;
      last_q <= 1'b0;
    end else begin
      if (accept && !drop) begin
        addr_q <= ptr;
        data_q <= enc;
        last_q <= bus.last;
      end
      if (state == WRITE) begin
        cnt <= cnt_inc;
        // Hold the pointer on the filling write instead of wrapping.
        if (cnt_inc != FULL) ptr <= ptr + ADDR_W'(1);
      end
    end
  end

`ifdef IENC_CHECK_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset)     err_q <= 1'b0;
    else if (drop) err_q <= 1'b1;
  end
  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_sc_ienc.sv
// tb_sc_ienc: self-checking bench for sc_ienc (built with ADDR_W = 2 so the
// memory-full path is reached quickly). Directed steps followed by random
// programs, all checked against a table-driven encoding model and a queue
// of expected memory writes.
module tb_sc_ienc;
  localparam int AW    = 2;
  localparam int DEPTH = 1 << AW;
  localparam int W     = AW + 32;
`ifdef IENC_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] dbg_state;

  always #5 clock = ~clock;

  sc_ienc_if #(.ADDR_W(AW)) bus ();

  sc_ienc #(.ADDR_W(AW)) dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  // ---------------- reference model ----------------
  logic [5:0] r_func [0:8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26,
                               6'h00, 6'h02, 6'h03, 6'h08};
  logic [5:0] i_op   [0:8] = '{6'h08, 6'h0C, 6'h0D, 6'h0E, 6'h23,
                               6'h2B, 6'h04, 6'h05, 6'h0F};
  logic [5:0] j_op   [0:1] = '{6'h02, 6'h03};

  int              n_cmp = 0;
  int              n_fail = 0;
  int              m_ptr;
  int              m_cnt;
  bit              m_done;
  bit              m_err;
  logic [AW-1:0]   m_last_addr;
  logic [31:0]     m_last_data;
  logic [W-1:0]    exp_q[$];

  function automatic logic [31:0] model_enc(input int m, input logic [4:0] rs,
      input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] sh,
      input logic [15:0] imm, input logic [25:0] tg);
    bit is_shift;
    bit is_jr;
    is_shift = (m >= 5) && (m <= 7);
    is_jr    = (m == 8);
    if (m < 9)
      return {6'b0, is_shift ? 5'd0 : rs, is_jr ? 5'd0 : rt,
              is_jr ? 5'd0 : rd, is_shift ? sh : 5'd0, r_func[m]};
    else if (m < 18)
      return {i_op[m-9], (m == 17) ? 5'd0 : rs, rt, imm};
    else if (m < 20)
      return {j_op[m-18], tg};
    return 32'h0;
  endfunction

  task automatic model_clear();
    m_ptr       = 0;
    m_cnt       = 0;
    m_done      = 1'b0;
    m_err       = 1'b0;
    m_last_addr = '0;
    m_last_data = '0;
    exp_q.delete();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      $error("%s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- scoreboard: memory write monitor ----------------
  always @(negedge clock) begin
    if (!reset && bus.im_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("spurious_write", 32'(bus.im_we), 32'd0);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        check("write_addr", 32'(bus.im_addr), 32'(e[W-1:32]));
        check("write_data", bus.im_data, e[31:0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic reset_dut();
    @(negedge clock);
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    @(negedge clock);
    model_clear();
    reset = 1'b0;
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_im_we",    32'(bus.im_we),    32'd0);
    check("rst_im_addr",  32'(bus.im_addr),  32'd0);
    check("rst_im_data",  bus.im_data,       32'd0);
    check("rst_count",    32'(bus.count),    32'd0);
    check("rst_done",     32'(bus.done),     32'd0);
    check("rst_err",      32'(bus.err),      32'd0);
  endtask

  task automatic accept(input logic [4:0] m, input logic [4:0] rs, input logic [4:0] rt,
      input logic [4:0] rd, input logic [4:0] sh, input logic [15:0] imm,
      input logic [25:0] tg, input bit last, output bit wrote);
    bit          ok;
    logic [31:0] e;
    wrote = 1'b0;
    ok    = 1'b0;
    @(negedge clock);
    bus.mnem = m; bus.rs = rs; bus.rt = rt; bus.rd = rd; bus.shamt = sh;
    bus.imm = imm; bus.target = tg; bus.last = last;
    bus.in_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (bus.in_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clock);
    end
    check("accept_wait", 32'(ok), 32'd1);
    if (!ok) begin
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clock);
    #1;
    bus.in_valid = 1'b0;
    e = model_enc(int'(m), rs, rt, rd, sh, imm, tg);
    if (m < 20 || !CHECK_EN) begin
      exp_q.push_back({AW'(m_ptr), e});
      m_last_addr = AW'(m_ptr);
      m_last_data = e;
      m_ptr++;
      m_cnt++;
      wrote = 1'b1;
      if (last || m_cnt == DEPTH) m_done = 1'b1;
    end else begin
      m_err = 1'b1;
      if (last) m_done = 1'b1;
    end
  endtask

  task automatic post_check(input bit wrote);
    @(negedge clock);
    if (wrote) begin
      check("ready_in_write", 32'(bus.in_ready), 32'd0);
      check("we_in_write",    32'(bus.im_we),    32'd1);
      @(negedge clock);
    end
    check("count",      32'(bus.count),    32'(m_cnt));
    check("done",       32'(bus.done),     32'(m_done));
    check("ready_next", 32'(bus.in_ready), 32'(!m_done));
    check("err",        32'(bus.err),      32'(CHECK_EN & m_err));
    check("we_idle",    32'(bus.im_we),    32'd0);
    check("addr_hold",  32'(bus.im_addr),  32'(m_last_addr));
    check("data_hold",  bus.im_data,       m_last_data);
  endtask

  task automatic push(input logic [4:0] m, input logic [4:0] rs, input logic [4:0] rt,
      input logic [4:0] rd, input logic [4:0] sh, input logic [15:0] imm,
      input logic [25:0] tg, input bit last);
    bit wrote;
    accept(m, rs, rt, rd, sh, imm, tg, last, wrote);
    post_check(wrote);
  endtask

  task automatic push_rand(input bit last);
    logic [4:0] m;
    m = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(20, 31)) : 5'($urandom_range(0, 19));
    push(m, 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
         16'($urandom), 26'($urandom), last);
  endtask

  // Offer instructions while loading is finished; none may be taken.
  task automatic try_ignored(input int n);
    @(negedge clock);
    bus.mnem = 5'($urandom_range(0, 19));
    bus.last = 1'b0;
    bus.in_valid = 1'b1;
    repeat (n) begin
      @(negedge clock);
      check("ignored_ready", 32'(bus.in_ready), 32'd0);
      check("ignored_done",  32'(bus.done),     32'd1);
      check("ignored_count", 32'(bus.count),    32'(m_cnt));
    end
    bus.in_valid = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit wrote;
    bus.in_valid = 1'b0;
    bus.mnem = '0; bus.rs = '0; bus.rt = '0; bus.rd = '0; bus.shamt = '0;
    bus.imm = '0; bus.target = '0; bus.last = 1'b0;
    model_clear();

    // add $3,$1,$2
    reset_dut();
    push(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b0);
    check("add_word", bus.im_data, 32'h0022_1820);
    check("add_addr", 32'(bus.im_addr), 32'd0);
    check("add_count", 32'(bus.count), 32'd1);

    // sll (rs ignored), lw, then jal flagged last
    reset_dut();
    push(5'd5, 5'd7, 5'd1, 5'd2, 5'd4, 16'h0, 26'h0, 1'b0);
    check("sll_word", bus.im_data, 32'h0001_1100);
    push(5'd13, 5'd5, 5'd4, 5'd0, 5'd0, 16'h0008, 26'h0, 1'b0);
    check("lw_word", bus.im_data, 32'h8CA4_0008);
    check("lw_addr", 32'(bus.im_addr), 32'd1);
    push(5'd19, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h10, 1'b1);
    check("jal_word", bus.im_data, 32'h0C00_0010);
    check("jal_done", 32'(bus.done), 32'd1);
    try_ignored(4);

    // memory full without last
    reset_dut();
    for (int i = 0; i < DEPTH; i++)
      push(5'($urandom_range(0, 19)), 5'($urandom), 5'($urandom), 5'($urandom),
           5'($urandom), 16'($urandom), 26'($urandom), 1'b0);
    check("full_count", 32'(bus.count), 32'(DEPTH));
    check("full_done", 32'(bus.done), 32'd1);
    check("full_addr", 32'(bus.im_addr), 32'(DEPTH - 1));
    try_ignored(4);

    // illegal mnemonic after a legal word, then an illegal one with last
    reset_dut();
    push(5'd9, 5'd3, 5'd4, 5'd0, 5'd0, 16'hFFFF, 26'h0, 1'b0);
    push(5'd25, 5'd1, 5'd2, 5'd3, 5'd4, 16'h1234, 26'h0, 1'b0);
    push(5'd31, 5'd1, 5'd2, 5'd3, 5'd4, 16'h1234, 26'h0, 1'b1);

    // reset while the write strobe is high
    reset_dut();
    push(5'd1, 5'd1, 5'd1, 5'd1, 5'd0, 16'h0, 26'h0, 1'b0);
    accept(5'd17, 5'd9, 5'd8, 5'd0, 5'd0, 16'hABCD, 26'h0, 1'b0, wrote);
    check("mid_write_we", 32'(bus.im_we), 32'(wrote));
    #1;
    reset = 1'b1;
    #1;
    check("async_we_drop", 32'(bus.im_we), 32'd0);
    check("async_count",   32'(bus.count), 32'd0);
    reset_dut();

    // random programs
    for (int p = 0; p < 25; p++) begin
      int len;
      reset_dut();
      len = $urandom_range(1, 6);
      for (int i = 0; i < len; i++) begin
        if (m_done) break;
        if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clock);
        push_rand((i == len - 1) && ($urandom_range(0, 1) == 1));
      end
      if (m_done) try_ignored(2);
    end

    @(negedge clock);
    check("pending_writes", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // ---------------- run-time bound ----------------
  initial begin
    #400000;
    $display("FAIL watchdog: run did not finish, dbg_state %0d", dbg_state);
    $fatal(1, "watchdog expired");
  end

endmodule
